// File: rtl/array_sum_accel_if.sv
// Control handshake and memory-port bundle for array_sum_accel.
// The accelerator connects through the slave modport; the host/memory side uses master.
interface array_sum_accel_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic              ap_start;
   logic              ap_idle;
   logic              ap_done;
   logic [DATA_W-1:0] ap_return;
   logic [DATA_W-1:0] n;
   logic [ADDR_W-1:0] a_address0;
   logic              a_ce0;
   logic              a_we0;
   logic [DATA_W-1:0] a_ad0;
   logic [DATA_W-1:0] a_q0;
   logic [ADDR_W-1:0] b_address0;
   logic              b_ce0;
   logic              b_we0;
   logic [DATA_W-1:0] b_ad0;
   logic [DATA_W-1:0] b_q0;

   modport slave (
      input  ap_start, n, a_q0, b_q0,
      output ap_idle, ap_done, ap_return,
             a_address0, a_ce0, a_we0, a_ad0,
             b_address0, b_ce0, b_we0, b_ad0
   );

   modport master (
      output ap_start, n, a_q0, b_q0,
      input  ap_idle, ap_done, ap_return,
             a_address0, a_ce0, a_we0, a_ad0,
             b_address0, b_ce0, b_we0, b_ad0
   );
endinterface

// File: rtl/array_sum_accel.sv
// Streams a[0..n-1], writes prefix sums to b[] and returns the total with an ap_ctrl_hs handshake.
// One element per clock; both memories have combinational read.
module array_sum_accel #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic                ap_clk,
   input  logic                ap_rst,
   array_sum_accel_if.slave    bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state, state_next;
   logic [DATA_W-1:0] i, n_reg, acc, acc_next, ret_q, sum;

   always_comb begin
      state_next     = state;
      acc_next       = acc;
      sum            = acc + bus.a_q0;
      bus.ap_idle    = 1'b0;
      bus.ap_done    = 1'b0;
      bus.ap_return  = ret_q;
      bus.a_address0 = '0;
      bus.a_ce0      = 1'b0;
      bus.a_we0      = 1'b0;
      bus.a_ad0      = '0;
      bus.b_address0 = '0;
      bus.b_ce0      = 1'b0;
      bus.b_we0      = 1'b0;
      bus.b_ad0      = '0;
      case (state)
         IDLE: begin
            bus.ap_idle = 1'b1;
            if (bus.ap_start) begin
               acc_next   = '0;
               state_next = ($signed(bus.n) > 0) ? RUN : DONE;
            end
         end
         RUN: begin
            bus.a_address0 = ADDR_W'(i);
            bus.a_ce0      = 1'b1;
            bus.b_address0 = ADDR_W'(i);
            bus.b_ce0      = 1'b1;
            bus.b_we0      = 1'b1;
            bus.b_ad0      = sum;
            acc_next       = sum;
            if (i == n_reg - DATA_W'(1))
               state_next = DONE;
         end
         DONE: begin
            bus.ap_done = 1'b1;
            state_next  = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state <= IDLE;
         i     <= '0;
         n_reg <= '0;
         acc   <= '0;
         ret_q <= '0;
      end else begin
         state <= state_next;
         acc   <= acc_next;
         if (state == IDLE && bus.ap_start) begin
            n_reg <= bus.n;
            i     <= '0;
         end else if (state == RUN) begin
            i <= i + DATA_W'(1);
         end
         // ap_return only moves on entry to DONE, so it holds between runs
         if (state_next == DONE && state != DONE)
            ret_q <= acc_next;
      end
   end
endmodule

// File: tb/tb_array_sum_accel.sv
// Self-checking bench for array_sum_accel: table-driven runs plus held-start, reset-abort
// and mid-run input-change sequences against a simple SRAM model.
module tb_array_sum_accel;
   logic ap_clk = 1'b0;
   logic ap_rst = 1'b1;
   always #5 ap_clk = ~ap_clk;

   array_sum_accel_if #(.DATA_W(32), .ADDR_W(32)) bus ();

   array_sum_accel #(.DATA_W(32), .ADDR_W(32)) dut (
      .ap_clk (ap_clk),
      .ap_rst (ap_rst),
      .bus    (bus.slave)
   );

   localparam logic [31:0] SENT = 32'hBAD0_BAD0;

   logic [31:0] a_mem [16];
   logic [31:0] b_mem [16];
   int          wr_cnt = 0;
   int          pass_cnt = 0;
   int          total = 0;

   assign bus.a_q0 = a_mem[bus.a_address0[3:0]];
   assign bus.b_q0 = '0;

   // Record B writes mid-cycle so the values seen are settled ones.
   always @(negedge ap_clk) begin
      if (bus.b_ce0 && bus.b_we0) begin
         b_mem[bus.b_address0[3:0]] = bus.b_ad0;
         wr_cnt++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic clear_b();
      for (int k = 0; k < 16; k++) b_mem[k] = SENT;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!bus.ap_done && lat < 200) begin
         @(posedge ap_clk); #1; lat++;
      end
   endtask

   // Called #1 after an edge with the DUT idle; returns in the DONE cycle.
   task automatic run_once(input logic [31:0] nv, output int lat);
      int more;
      bus.n = nv;
      bus.ap_start = 1'b1;
      @(posedge ap_clk); #1;
      bus.ap_start = 1'b0;
      wait_done(more);
      lat = more + 1;
   endtask

   typedef struct {
      logic [31:0] n;
      logic [31:0] a [10];
      logic [31:0] b [10];
      logic [31:0] ret;
      int          lat;
      int          writes;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int lat, w0, untouched;

      vecs[0] = '{n: 32'd10, a: '{1,2,3,4,5,6,7,8,9,10},
                  b: '{1,3,6,10,15,21,28,36,45,55}, ret: 32'd55, lat: 11, writes: 10};
      vecs[1] = '{n: 32'd0, a: '{9,9,9,9,9,9,9,9,9,9},
                  b: '{0,0,0,0,0,0,0,0,0,0}, ret: 32'd0, lat: 1, writes: 0};
      vecs[2] = '{n: -32'sd5, a: '{9,9,9,9,9,9,9,9,9,9},
                  b: '{0,0,0,0,0,0,0,0,0,0}, ret: 32'd0, lat: 1, writes: 0};
      vecs[3] = '{n: 32'd2, a: '{32'hFFFF_FFFF,2,5,5,5,5,5,5,5,5},
                  b: '{32'hFFFF_FFFF,1,0,0,0,0,0,0,0,0}, ret: 32'd1, lat: 3, writes: 2};
      vecs[4] = '{n: 32'd1, a: '{7,8,8,8,8,8,8,8,8,8},
                  b: '{7,0,0,0,0,0,0,0,0,0}, ret: 32'd7, lat: 2, writes: 1};
      vecs[5] = '{n: 32'd3, a: '{100,200,300,4,4,4,4,4,4,4},
                  b: '{100,300,600,0,0,0,0,0,0,0}, ret: 32'd600, lat: 4, writes: 3};

      for (int k = 0; k < 16; k++) a_mem[k] = '0;
      clear_b();
      bus.ap_start = 1'b0;
      bus.n = '0;

      repeat (2) @(posedge ap_clk);
      #1;
      check("rst_idle",   {31'd0, bus.ap_idle}, 32'd1);
      check("rst_done",   {31'd0, bus.ap_done}, 32'd0);
      check("rst_return", bus.ap_return, 32'd0);
      check("rst_ce",     {29'd0, bus.a_ce0, bus.b_ce0, bus.b_we0}, 32'd0);
      check("rst_addr",   bus.a_address0 | bus.b_address0 | bus.b_ad0, 32'd0);
      ap_rst = 1'b0;
      @(posedge ap_clk); #1;

      for (int v = 0; v < 6; v++) begin
         for (int k = 0; k < 16; k++) a_mem[k] = (k < 10) ? vecs[v].a[k] : 32'd0;
         clear_b();
         w0 = wr_cnt;
         check($sformatf("v%0d_idle", v), {31'd0, bus.ap_idle}, 32'd1);
         run_once(vecs[v].n, lat);
         check($sformatf("v%0d_latency", v), lat, vecs[v].lat);
         check($sformatf("v%0d_return", v), bus.ap_return, vecs[v].ret);
         check($sformatf("v%0d_awe", v), {31'd0, bus.a_we0}, 32'd0);
         check($sformatf("v%0d_writes", v), wr_cnt - w0, vecs[v].writes);
         for (int k = 0; k < vecs[v].writes; k++)
            check($sformatf("v%0d_b%0d", v, k), b_mem[k], vecs[v].b[k]);
         @(posedge ap_clk); #1;
         check($sformatf("v%0d_done_pulse", v), {31'd0, bus.ap_done}, 32'd0);
         check($sformatf("v%0d_return_hold", v), bus.ap_return, vecs[v].ret);
      end

      // ap_start held high: back-to-back runs with one idle cycle between them
      for (int k = 0; k < 10; k++) a_mem[k] = k + 1;
      bus.n = 32'd10;
      bus.ap_start = 1'b1;
      for (int r = 0; r < 2; r++) begin
         wait_done(lat);
         check($sformatf("held%0d_return", r), bus.ap_return, 32'd55);
         @(posedge ap_clk); #1;
         check($sformatf("held%0d_done_pulse", r), {31'd0, bus.ap_done}, 32'd0);
         check($sformatf("held%0d_idle_gap", r), {31'd0, bus.ap_idle}, 32'd1);
         @(posedge ap_clk); #1;
         check($sformatf("held%0d_restarted", r), {31'd0, bus.ap_idle}, 32'd0);
      end
      bus.ap_start = 1'b0;
      wait_done(lat);
      @(posedge ap_clk); #1;

      // Reset while processing element 4 aborts the run
      clear_b();
      bus.n = 32'd10;
      bus.ap_start = 1'b1;
      @(posedge ap_clk); #1;
      bus.ap_start = 1'b0;
      lat = 0;
      while (!(bus.b_we0 && bus.b_address0 == 32'd4) && lat < 50) begin
         @(posedge ap_clk); #1; lat++;
      end
      check("abort_reach_i4", {31'd0, bus.b_we0}, 32'd1);
      ap_rst = 1'b1;
      @(posedge ap_clk); #1;
      ap_rst = 1'b0;
      check("abort_idle",   {31'd0, bus.ap_idle}, 32'd1);
      check("abort_return", bus.ap_return, 32'd0);
      check("abort_we",     {31'd0, bus.b_we0}, 32'd0);
      repeat (5) @(posedge ap_clk);
      #1;
      untouched = 0;
      for (int k = 5; k < 10; k++) if (b_mem[k] === SENT) untouched++;
      check("abort_no_b5_9", untouched, 32'd5);
      check("abort_b3", b_mem[3], 32'd10);
      run_once(32'd10, lat);
      check("restart_return", bus.ap_return, 32'd55);
      check("restart_b9", b_mem[9], 32'd55);
      @(posedge ap_clk); #1;

      // ap_start dropped and n changed mid-run: the latched n governs
      clear_b();
      bus.n = 32'd10;
      bus.ap_start = 1'b1;
      @(posedge ap_clk); #1;
      repeat (2) @(posedge ap_clk);
      #1;
      bus.ap_start = 1'b0;
      bus.n = 32'd3;
      wait_done(lat);
      check("nchg_latency", lat + 3, 32'd11);
      check("nchg_return", bus.ap_return, 32'd55);
      check("nchg_b9", b_mem[9], 32'd55);
      @(posedge ap_clk); #1;
      check("nchg_idle", {31'd0, bus.ap_idle}, 32'd1);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
